// File: rtl/instr_fetch.sv
// instr_fetch: program counter and ROM fetch unit, hands instructions to execute over valid/ready
module instr_fetch #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [DATA_W-1:0] HALT_INSTR = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read,
    output logic              rom_ena,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
    state_t state, state_d;
    logic hs;
    assign hs = instr_valid && instr_ready;
    assign rom_addr = pc;
    assign rom_read = state == FETCH;
    assign rom_ena = state == FETCH;
    assign halted = state == HALT;
    assign opcode = instr[DATA_W-1 -: 4];
    assign operand = instr[3:0];
    always_comb begin
        state_d = state == IDLE  ? (run ? FETCH : IDLE) :
                  state == FETCH ? HOLD :
                  state == HOLD  ? (!hs ? HOLD : instr == HALT_INSTR ? HALT : run ? FETCH : IDLE) :
                  HALT;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_PC;
            instr <= '0;
            instr_valid <= 1'b0;
        end else begin
            state <= state_d;
            if (state == FETCH) begin
                instr <= rom_data;
                pc <= pc + ADDR_W'(1);
                instr_valid <= 1'b1;
            end else if (state == HOLD && hs) begin
                instr_valid <= 1'b0;
                if (instr != HALT_INSTR && jmp_en)
                    pc <= jmp_addr;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch, plus a RESET_PC=FF instance for wrap
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst_n, run, instr_ready, jmp_en;
    logic [7:0] jmp_addr;
    logic [7:0] rom [256];
    logic [7:0] rom_addr, rom_data, instr, pc;
    logic [3:0] opcode, operand;
    logic rom_read, rom_ena, instr_valid, halted;
    logic [7:0] w_rom_addr, w_rom_data, w_instr, w_pc;
    logic [3:0] w_opcode, w_operand;
    logic w_rom_read, w_rom_ena, w_instr_valid, w_halted;
    logic [7:0] sb [$];
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    assign rom_data = (rom_read && rom_ena) ? rom[rom_addr] : 8'hxx;
    assign w_rom_data = (w_rom_read && w_rom_ena) ? rom[w_rom_addr] : 8'hxx;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .rom_addr(rom_addr), .rom_read(rom_read), .rom_ena(rom_ena), .rom_data(rom_data),
        .instr(instr), .opcode(opcode), .operand(operand),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pc(pc), .halted(halted)
    );

    instr_fetch #(.RESET_PC(8'hFF)) u_wrap (
        .clk(clk), .rst_n(rst_n), .run(run),
        .rom_addr(w_rom_addr), .rom_read(w_rom_read), .rom_ena(w_rom_ena), .rom_data(w_rom_data),
        .instr(w_instr), .opcode(w_opcode), .operand(w_operand),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pc(w_pc), .halted(w_halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic take(input logic [7:0] exp_pc);
        logic [7:0] e;
        chk("sb_nonempty", 8'(sb.size() != 0), 8'd1);
        e = sb.size() != 0 ? sb.pop_front() : 8'h00;
        chk("valid", 8'(instr_valid), 8'd1);
        chk("instr", instr, e);
        chk("opcode", 8'(opcode), 8'(e[7:4]));
        chk("operand", 8'(operand), 8'(e[3:0]));
        chk("pc", pc, exp_pc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, 8'h00);
        chk({tag, "_rom_addr"}, rom_addr, 8'h00);
        chk({tag, "_instr"}, instr, 8'h00);
        chk({tag, "_opcode"}, 8'(opcode), 8'h00);
        chk({tag, "_operand"}, 8'(operand), 8'h00);
        chk({tag, "_valid"}, 8'(instr_valid), 8'h00);
        chk({tag, "_halted"}, 8'(halted), 8'h00);
        chk({tag, "_rd_en"}, 8'({rom_read, rom_ena}), 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'hD4; rom[1] = 8'h51; rom[2] = 8'hDA; rom[3] = 8'h52;
        rom[8'h40] = 8'h77; rom[8'hFF] = 8'h12;
        run = 1'b0; instr_ready = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00;
        rst_n = 1'b0;
        step();
        step();
        chk_reset("rst");
        chk("wrap_rst_pc", w_pc, 8'hFF);
        rst_n = 1'b1;
        step();
        chk("idle_no_read", 8'(rom_read), 8'd0);

        // streaming with ready held: FETCH/HOLD alternate
        run = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(rom[i]);
            step();
            chk("fetch_read", 8'(rom_read && rom_ena), 8'd1);
            chk("fetch_addr", rom_addr, 8'(i));
            chk("fetch_valid_low", 8'(instr_valid), 8'd0);
            if (i == 0) chk("wrap_first_addr", w_rom_addr, 8'hFF);
            if (i == 1) chk("wrap_second_addr", w_rom_addr, 8'h00);
            step();
            take(8'(i + 1));
            if (i == 0) chk("wrap_pc_after", w_pc, 8'h00);
        end
        run = 1'b0;
        step();
        step();
        chk("run_low_idle", 8'(rom_read), 8'd0);
        chk("run_low_valid", 8'(instr_valid), 8'd0);

        // backpressure with an ignored jump request
        do_reset();
        run = 1'b1; instr_ready = 1'b0;
        step();
        sb.push_back(8'hD4);
        step();
        take(8'h01);
        jmp_en = 1'b1; jmp_addr = 8'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_instr", instr, 8'hD4);
            chk("bp_valid", 8'(instr_valid), 8'd1);
            chk("bp_rd_en", 8'({rom_read, rom_ena}), 8'h00);
            chk("bp_pc", pc, 8'h01);
        end
        jmp_en = 1'b0; instr_ready = 1'b1;
        step();
        chk("bp_release_addr", rom_addr, 8'h01);
        chk("bp_release_read", 8'(rom_read), 8'd1);
        sb.push_back(8'h51);
        step();
        take(8'h02);
        step();
        chk("pre_jmp_addr", rom_addr, 8'h02);
        sb.push_back(8'hDA);
        step();
        take(8'h03);
        jmp_en = 1'b1; jmp_addr = 8'h40;
        step();
        jmp_en = 1'b0;
        chk("jmp_fetch_addr", rom_addr, 8'h40);
        chk("jmp_fetch_read", 8'(rom_read), 8'd1);
        sb.push_back(8'h77);
        step();
        take(8'h41);
        run = 1'b0;
        step();

        // HALT byte at address 3
        rom[3] = 8'hFF;
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(rom[i]);
            step();
            step();
            take(8'(i + 1));
        end
        step();
        chk("halt_halted", 8'(halted), 8'd1);
        chk("halt_pc", pc, 8'h04);
        chk("halt_valid", 8'(instr_valid), 8'd0);
        for (int i = 0; i < 4; i++) begin
            run = i[0]; jmp_en = ~i[0]; jmp_addr = 8'h10;
            step();
            chk("halt_stay", 8'(halted), 8'd1);
            chk("halt_no_read", 8'(rom_read || rom_ena), 8'd0);
            chk("halt_pc_hold", pc, 8'h04);
        end
        jmp_en = 1'b0;
        rst_n = 1'b0;
        step();
        chk("halt_cleared", 8'(halted), 8'd0);
        rst_n = 1'b1;

        // reset while an instruction is pending in HOLD
        run = 1'b1; instr_ready = 1'b0;
        step();
        step();
        chk("midhold_valid", 8'(instr_valid), 8'd1);
        chk("midhold_instr", instr, 8'hD4);
        rst_n = 1'b0;
        step();
        chk_reset("midhold_rst");
        rst_n = 1'b1; instr_ready = 1'b1;
        step();
        chk("post_rst_fetch_addr", rom_addr, 8'h00);
        chk("post_rst_fetch_read", 8'(rom_read), 8'd1);
        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
